// File: rtl/spi_rd_port_ctrl.sv
// Core-side controller for one SPI read port: pad synchronisers, RX FWFT FIFO, TX bus driver.
// Optional sticky overflow flag output rx_ovf when SPI_RD_OVF_FLAG_EN is defined.
module spi_rd_port_ctrl #(
  parameter int unsigned SPI_WIDTH  = 32,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned NF_MARGIN  = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 O_spi_sck_rd,
  input  logic                 O_spi_cs_n_rd,
  input  logic                 OE_req_rd,
  input  logic [SPI_WIDTH-1:0] I_spi_data_rd,
  output logic [SPI_WIDTH-1:0] O_spi_data_rd,
  output logic                 pad_OE_rd,
  output logic                 near_full_rd,
  output logic                 config_req_rd,
  input  logic                 rx_rd_en,
  output logic [SPI_WIDTH-1:0] rx_dout,
  output logic                 rx_empty,
  input  logic [SPI_WIDTH-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_pop,
`ifdef SPI_RD_OVF_FLAG_EN
  output logic                 rx_ovf,
`endif
  input  logic                 cfg_req
);

  localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W    = PTR_W + 1;
  localparam int unsigned NF_LEVEL = FIFO_DEPTH - NF_MARGIN;

  typedef enum logic [1:0] {IDLE, RX, TURN, TX} state_t;

  state_t state, state_d;

  logic [2:0]           sck_q;
  logic [2:0]           cs_q;
  logic [1:0]           oe_q;
  logic [SPI_WIDTH-1:0] data_q1, data_q2;
  logic                 sck_rise, cs_fall, cs_n_s, oe_s;
  logic                 push, load;

  logic [SPI_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [CNT_W-1:0]     count;
  logic                 full, pop, wr_en;

  // Two-flop synchronisers; cs_n keeps a third stage so only a real falling edge opens a frame
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sck_q   <= '0;
      cs_q    <= '1;
      oe_q    <= '0;
      data_q1 <= '0;
      data_q2 <= '0;
    end else begin
      sck_q   <= {sck_q[1:0], O_spi_sck_rd};
      cs_q    <= {cs_q[1:0], O_spi_cs_n_rd};
      oe_q    <= {oe_q[0], OE_req_rd};
      data_q1 <= I_spi_data_rd;
      data_q2 <= data_q1;
    end
  end

  assign sck_rise = sck_q[1] & ~sck_q[2];
  assign cs_n_s   = cs_q[1];
  assign cs_fall  = ~cs_q[1] & cs_q[2];
  assign oe_s     = oe_q[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_d;
  end

  // Frame sequencing; cs_n release takes priority over any data action
  always_comb begin
    state_d = state;
    push    = 1'b0;
    load    = 1'b0;
    case (state)
      IDLE: if (cs_fall) state_d = oe_s ? TURN : RX;
      RX: begin
        if (cs_n_s) state_d = IDLE;
        else        push    = sck_rise;
      end
      TURN: begin
        if (cs_n_s) begin
          state_d = IDLE;
        end else begin
          load    = 1'b1;
          state_d = TX;
        end
      end
      TX: begin
        if (cs_n_s) state_d = IDLE;
        else        load    = sck_rise;
      end
      default: state_d = IDLE;
    endcase
  end

  // Pad-facing outputs registered from the next state so OE tracks the state change
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      O_spi_data_rd <= '0;
      pad_OE_rd     <= 1'b0;
      tx_pop        <= 1'b0;
      config_req_rd <= 1'b0;
    end else begin
      pad_OE_rd <= (state_d == TURN) || (state_d == TX);
      tx_pop    <= load & tx_valid;
      if (load) O_spi_data_rd <= tx_valid ? tx_data : '0;
      if (cfg_req)                                   config_req_rd <= 1'b1;
      else if ((state == IDLE) && (state_d != IDLE)) config_req_rd <= 1'b0;
    end
  end

  assign full  = (count == CNT_W'(FIFO_DEPTH));
  assign pop   = rx_rd_en & (count != '0);
  assign wr_en = push & (~full | pop);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= data_q2;
  end

  // FIFO bookkeeping; status and head word lag the count by one cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      rx_empty     <= 1'b1;
      rx_dout      <= '0;
      near_full_rd <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      rx_empty     <= (count == '0);
      rx_dout      <= (count == '0) ? '0 : mem[rd_ptr];
      near_full_rd <= (count >= CNT_W'(NF_LEVEL));
    end
  end

`ifdef SPI_RD_OVF_FLAG_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                  rx_ovf <= 1'b0;
    else if (push & full & ~pop)   rx_ovf <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_spi_rd_port_ctrl.sv
// Directed/randomised bench for spi_rd_port_ctrl with a queue-based FIFO model and pin-level SPI tasks.
module tb_spi_rd_port_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        sck, cs_n, oe_req;
  logic [31:0] i_data, o_data;
  logic        pad_oe, near_full, config_req;
  logic        rx_rd_en, rx_empty;
  logic [31:0] rx_dout;
  logic [31:0] tx_data;
  logic        tx_valid, tx_pop, cfg_req;
`ifdef SPI_RD_OVF_FLAG_EN
  logic        rx_ovf;
`endif

  int          total = 0;
  int          bad   = 0;
  int          pop_cnt = 0;
  logic [31:0] q[$];
  bit          ovf_exp = 1'b0;

  spi_rd_port_ctrl dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .O_spi_sck_rd  (sck),
    .O_spi_cs_n_rd (cs_n),
    .OE_req_rd     (oe_req),
    .I_spi_data_rd (i_data),
    .O_spi_data_rd (o_data),
    .pad_OE_rd     (pad_oe),
    .near_full_rd  (near_full),
    .config_req_rd (config_req),
    .rx_rd_en      (rx_rd_en),
    .rx_dout       (rx_dout),
    .rx_empty      (rx_empty),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_pop        (tx_pop),
`ifdef SPI_RD_OVF_FLAG_EN
    .rx_ovf        (rx_ovf),
`endif
    .cfg_req       (cfg_req)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (tx_pop) pop_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Capacity-16 queue: a push beyond capacity is lost and raises the overflow expectation
  task automatic model_push(input logic [31:0] w);
    if (q.size() < 16) q.push_back(w);
    else               ovf_exp = 1'b1;
  endtask

  task automatic check_head(input string tag);
    chk({tag, "_empty"}, 32'(rx_empty), 32'(q.size() == 0));
    chk({tag, "_nf"}, 32'(near_full), 32'(q.size() >= 12));
    if (q.size() > 0) chk({tag, "_dout"}, rx_dout, q[0]);
  endtask

  // Returns three cycles after the rise: the FIFO write has just happened, outputs not yet updated
  task automatic sck_rise_only(input logic [31:0] w);
    i_data = w;
    tick(2);
    sck = 1'b1;
    tick(3);
    model_push(w);
  endtask

  task automatic sck_fall();
    tick(2);
    sck = 1'b0;
    tick(4);
  endtask

  task automatic full_push(input logic [31:0] w, input string tag);
    sck_rise_only(w);
    tick(1);
    check_head(tag);
    sck_fall();
  endtask

  task automatic pop_one();
    rx_rd_en = 1'b1;
    tick(1);
    rx_rd_en = 1'b0;
    tick(1);
    if (q.size() > 0) q.delete(0);
  endtask

  initial begin
    int          n, base;
    logic [31:0] w;

    reset_n = 1'b0; sck = 1'b0; cs_n = 1'b1; oe_req = 1'b0; i_data = '0;
    rx_rd_en = 1'b0; tx_data = '0; tx_valid = 1'b0; cfg_req = 1'b0;
    tick(2);
    chk("rst_data", o_data, 32'h0);
    chk("rst_oe", 32'(pad_oe), 32'h0);
    chk("rst_nf", 32'(near_full), 32'h0);
    chk("rst_cfg", 32'(config_req), 32'h0);
    chk("rst_txpop", 32'(tx_pop), 32'h0);
    chk("rst_empty", 32'(rx_empty), 32'h1);
    chk("rst_dout", rx_dout, 32'h0);
`ifdef SPI_RD_OVF_FLAG_EN
    chk("rst_ovf", 32'(rx_ovf), 32'h0);
`endif
    reset_n = 1'b1;
    tick(2);

    // RX burst of five fixed words
    oe_req = 1'b0; cs_n = 1'b0;
    tick(6);
    for (int i = 0; i < 5; i++) begin
      w = 32'(32'h11111111 * (i + 1));
      sck_rise_only(w);
      if (i == 0) chk("rx_lat_pre", 32'(rx_empty), 32'h1);
      tick(1);
      check_head("rx_burst");
      chk("rx_burst_oe", 32'(pad_oe), 32'h0);
      sck_fall();
    end
    cs_n = 1'b1;
    tick(4);
    for (int i = 0; i < 5; i++) begin
      check_head("rx_drain");
      pop_one();
    end
    check_head("rx_drained");
    pop_one();
    check_head("pop_empty");

    // Random RX frame with random interleaved pops
    cs_n = 1'b0;
    tick(6);
    n = int'($urandom_range(3, 8));
    for (int i = 0; i < n; i++) begin
      full_push($urandom, "rnd_push");
      if ($urandom_range(0, 1) == 1) begin
        pop_one();
        check_head("rnd_pop");
      end
    end
    cs_n = 1'b1;
    tick(4);
    while (q.size() > 0) begin
      pop_one();
      check_head("rnd_drain");
    end

    // Fill to near-full, then overflow
    cs_n = 1'b0;
    tick(6);
    for (int i = 1; i <= 17; i++) begin
      sck_rise_only($urandom);
      if (i == 12) chk("nf_pre", 32'(near_full), 32'h0);
`ifdef SPI_RD_OVF_FLAG_EN
      chk("ovf", 32'(rx_ovf), 32'(ovf_exp));
`endif
      tick(1);
      if (i == 12) chk("nf_post", 32'(near_full), 32'h1);
      sck_fall();
    end
    check_head("full");

    // Push coinciding with a pop while full is accepted
    w = $urandom;
    i_data = w;
    tick(2);
    sck = 1'b1;
    tick(2);
    rx_rd_en = 1'b1;
    tick(1);
    rx_rd_en = 1'b0;
    q.delete(0);
    q.push_back(w);
    tick(1);
    check_head("push_pop_full");
    sck_fall();
    cs_n = 1'b1;
    tick(4);
    while (q.size() > 0) begin
      pop_one();
      check_head("full_drain");
    end

    // Transmit frame with two valid words
    base = pop_cnt;
    oe_req = 1'b1; tx_data = 32'hA5A5A5A5; tx_valid = 1'b1; cs_n = 1'b0;
    tick(2);
    chk("tx_oe_pre", 32'(pad_oe), 32'h0);
    tick(1);
    chk("tx_oe_on", 32'(pad_oe), 32'h1);
    chk("tx_pop_pre", 32'(tx_pop), 32'h0);
    tick(1);
    chk("tx_word0", o_data, 32'hA5A5A5A5);
    chk("tx_pop0", 32'(tx_pop), 32'h1);
    tx_data = 32'h5A5A5A5A; oe_req = 1'b0;
    tick(2);
    chk("tx_pop0_end", 32'(tx_pop), 32'h0);
    sck = 1'b1;
    tick(2);
    chk("tx_hold0", o_data, 32'hA5A5A5A5);
    tick(1);
    chk("tx_word1", o_data, 32'h5A5A5A5A);
    chk("tx_pop1", 32'(tx_pop), 32'h1);
    tx_valid = 1'b0;
    tick(3);
    sck = 1'b0;
    tick(4);
    chk("tx_oe_ignore_req", 32'(pad_oe), 32'h1);
    cs_n = 1'b1;
    tick(2);
    chk("tx_oe_hold", 32'(pad_oe), 32'h1);
    tick(1);
    chk("tx_oe_off", 32'(pad_oe), 32'h0);
    chk("tx_bus_hold", o_data, 32'h5A5A5A5A);
    chk("tx_pops", 32'(pop_cnt - base), 32'd2);
    tick(3);

    // Underrun at turnaround, then one random word on the first sck
    base = pop_cnt;
    w = $urandom;
    oe_req = 1'b1; tx_valid = 1'b0; tx_data = w; cs_n = 1'b0;
    tick(4);
    chk("turn_underrun_bus", o_data, 32'h0);
    chk("turn_underrun_pop", 32'(tx_pop), 32'h0);
    tick(2);
    tx_valid = 1'b1;
    sck = 1'b1;
    tick(3);
    chk("tx_rnd_word", o_data, w);
    chk("tx_rnd_pop", 32'(tx_pop), 32'h1);
    tx_valid = 1'b0;
    tick(3);
    sck = 1'b0;
    tick(4);
    cs_n = 1'b1;
    tick(4);
    chk("underrun_pops", 32'(pop_cnt - base), 32'd1);
    chk("underrun_oe_off", 32'(pad_oe), 32'h0);
    oe_req = 1'b0;

    // Config request held until the next frame starts
    cfg_req = 1'b1;
    tick(1);
    cfg_req = 1'b0;
    chk("cfg_set", 32'(config_req), 32'h1);
    tick(5);
    chk("cfg_hold", 32'(config_req), 32'h1);
    cs_n = 1'b0;
    tick(2);
    chk("cfg_pre_clear", 32'(config_req), 32'h1);
    tick(1);
    chk("cfg_clear", 32'(config_req), 32'h0);
    tick(3);
    for (int i = 0; i < 3; i++) full_push($urandom, "pre_reset");

    // Reset in the middle of the RX frame
    reset_n = 1'b0;
    #1;
    q.delete();
    chk("mid_rst_empty", 32'(rx_empty), 32'h1);
    chk("mid_rst_dout", rx_dout, 32'h0);
    chk("mid_rst_data", o_data, 32'h0);
    chk("mid_rst_oe", 32'(pad_oe), 32'h0);
    chk("mid_rst_nf", 32'(near_full), 32'h0);
    chk("mid_rst_cfg", 32'(config_req), 32'h0);
    chk("mid_rst_txpop", 32'(tx_pop), 32'h0);
`ifdef SPI_RD_OVF_FLAG_EN
    chk("mid_rst_ovf", 32'(rx_ovf), 32'h0);
`endif
    cs_n = 1'b1;
    tick(2);
    reset_n = 1'b1;
    tick(4);
    check_head("post_reset");

    // cfg_req in the same cycle the FSM leaves IDLE: set wins
    cs_n = 1'b0;
    tick(2);
    cfg_req = 1'b1;
    tick(1);
    cfg_req = 1'b0;
    chk("cfg_set_wins", 32'(config_req), 32'h1);
    cs_n = 1'b1;
    tick(4);
    chk("cfg_set_wins_hold", 32'(config_req), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
